// File: rtl/axis_spm_scan_gen_if.sv
// Minimal AXI-Stream data path (tdata/tvalid) used for the scan coordinate outputs.
// There is no tready: the downstream rotation/offset stage is always ready.
interface axis_spm_scan_gen_if #(
   parameter int W = 32
) ();
   logic [W-1:0] tdata;
   logic         tvalid;

   modport master (output tdata, output tvalid);
   modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/axis_spm_scan_gen.sv
// Serpentine (forward/backward) raster scan generator for an SPM.
// It produces saturated X/Y scan coordinates, a per-pixel strobe and line/pixel indices.
//
// state | meaning
// IDLE  | waiting for an accepted start; coordinates hold
// FWD   | forward pass of the current line, xs increases by dx per pixel
// BWD   | backward pass of the current line, xs decreases by dx per pixel
// YSTEP | one cycle: ys += dy, advance to the next line
// DONE  | one cycle: done pulse, then back to IDLE
module axis_spm_scan_gen #(
   parameter int CNTW              = 16,
   parameter int SAXIS_TDATA_WIDTH = 32
) (
   input  logic                                a_clk,
   input  logic                                a_resetn,
   input  logic                                start,
   input  logic                                abort,
   input  logic [CNTW-1:0]                     nx,
   input  logic [CNTW-1:0]                     ny,
   input  logic signed [SAXIS_TDATA_WIDTH-1:0] dx,
   input  logic signed [SAXIS_TDATA_WIDTH-1:0] dy,
   input  logic [31:0]                         dwell,
   input  logic signed [SAXIS_TDATA_WIDTH-1:0] x_start,
   input  logic signed [SAXIS_TDATA_WIDTH-1:0] y_start,
   axis_spm_scan_gen_if.master                 M_AXIS_XS,
   axis_spm_scan_gen_if.master                 M_AXIS_YS,
   output logic                                pixel_strobe,
   output logic                                line_dir,
   output logic [CNTW-1:0]                     pixel_idx,
   output logic [CNTW-1:0]                     line_idx,
   output logic                                busy,
   output logic                                done
);

   localparam int W = SAXIS_TDATA_WIDTH;
   localparam logic signed [W:0] SMAX = $signed({2'b00, {(W-1){1'b1}}});
   localparam logic signed [W:0] SMIN = -SMAX;

   typedef enum logic [2:0] {IDLE, FWD, BWD, YSTEP, DONE} state_t;

   state_t                state;
   logic signed [W-1:0]   xs, ys;
   logic signed [W-1:0]   dx_l, dy_l;
   logic [CNTW-1:0]       nx_l, ny_l;
   logic [31:0]           dwm1;
   logic [31:0]           cnt;

   logic signed [W:0]     xs_add, xs_sub, ys_add;
   logic [CNTW-1:0]       px_last, ln_last;
   logic                  dw_single, cnt_next_tc;

   function automatic logic signed [W-1:0] sat(input logic signed [W:0] s);
      if (s > SMAX)      return SMAX[W-1:0];
      else if (s < SMIN) return SMIN[W-1:0];
      else               return s[W-1:0];
   endfunction

   always_comb begin
      xs_add      = $signed({xs[W-1], xs}) + $signed({dx_l[W-1], dx_l});
      xs_sub      = $signed({xs[W-1], xs}) - $signed({dx_l[W-1], dx_l});
      ys_add      = $signed({ys[W-1], ys}) + $signed({dy_l[W-1], dy_l});
      px_last     = nx_l - CNTW'(1);
      ln_last     = ny_l - CNTW'(1);
      dw_single   = (dwm1 == 32'd0);
      cnt_next_tc = ((cnt + 32'd1) == dwm1);
   end

   // pixel_strobe is registered one cycle ahead, so it doubles as the
   // dwell terminal-count flag for the current cycle (cnt == dwm1).
   always_ff @(posedge a_clk) begin
      if (!a_resetn) begin
         state        <= IDLE;
         xs           <= '0;
         ys           <= '0;
         dx_l         <= '0;
         dy_l         <= '0;
         nx_l         <= '0;
         ny_l         <= '0;
         dwm1         <= '0;
         cnt          <= '0;
         pixel_idx    <= '0;
         line_idx     <= '0;
         line_dir     <= 1'b0;
         pixel_strobe <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state        <= IDLE;
            busy         <= 1'b0;
            pixel_strobe <= 1'b0;
            cnt          <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && (nx != '0) && (ny != '0)) begin
                     nx_l         <= nx;
                     ny_l         <= ny;
                     dx_l         <= dx;
                     dy_l         <= dy;
                     dwm1         <= (dwell == 32'd0) ? 32'd0 : dwell - 32'd1;
                     xs           <= x_start;
                     ys           <= y_start;
                     pixel_idx    <= '0;
                     line_idx     <= '0;
                     line_dir     <= 1'b0;
                     cnt          <= '0;
                     pixel_strobe <= (dwell <= 32'd1);
                     busy         <= 1'b1;
                     state        <= FWD;
                  end
               end
               FWD: begin
                  if (pixel_strobe) begin
                     cnt          <= '0;
                     pixel_strobe <= dw_single;
                     if (pixel_idx != px_last) begin
                        xs        <= sat(xs_add);
                        pixel_idx <= pixel_idx + CNTW'(1);
                     end else begin
                        state     <= BWD;
                        line_dir  <= 1'b1;
                        pixel_idx <= '0;
                     end
                  end else begin
                     cnt          <= cnt + 32'd1;
                     pixel_strobe <= cnt_next_tc;
                  end
               end
               BWD: begin
                  if (pixel_strobe) begin
                     cnt <= '0;
                     if (pixel_idx != px_last) begin
                        xs           <= sat(xs_sub);
                        pixel_idx    <= pixel_idx + CNTW'(1);
                        pixel_strobe <= dw_single;
                     end else if (line_idx != ln_last) begin
                        pixel_strobe <= 1'b0;
                        state        <= YSTEP;
                     end else begin
                        pixel_strobe <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                     end
                  end else begin
                     cnt          <= cnt + 32'd1;
                     pixel_strobe <= cnt_next_tc;
                  end
               end
               YSTEP: begin
                  ys           <= sat(ys_add);
                  line_idx     <= line_idx + CNTW'(1);
                  pixel_idx    <= '0;
                  line_dir     <= 1'b0;
                  cnt          <= '0;
                  pixel_strobe <= dw_single;
                  state        <= FWD;
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign M_AXIS_XS.tdata  = xs;
   assign M_AXIS_YS.tdata  = ys;
   assign M_AXIS_XS.tvalid = 1'b1;
   assign M_AXIS_YS.tvalid = 1'b1;

endmodule

// File: tb/tb_axis_spm_scan_gen.sv
// Bench for axis_spm_scan_gen: a table of scans plus random scans, each checked cycle by cycle
// against a trace built from nested line/pixel/dwell loops, and hand-written abort/reset sequences.
module tb_axis_spm_scan_gen;

   logic               a_clk = 1'b0;
   logic               a_resetn, start, abort;
   logic [15:0]        nx, ny;
   logic signed [31:0] dx, dy, x_start, y_start;
   logic [31:0]        dwell;
   logic               pixel_strobe, line_dir, busy, done;
   logic [15:0]        pixel_idx, line_idx;

   always #5 a_clk = ~a_clk;

   axis_spm_scan_gen_if #(.W(32)) xs_if ();
   axis_spm_scan_gen_if #(.W(32)) ys_if ();

   axis_spm_scan_gen #(.CNTW(16), .SAXIS_TDATA_WIDTH(32)) dut (
      .a_clk        (a_clk),
      .a_resetn     (a_resetn),
      .start        (start),
      .abort        (abort),
      .nx           (nx),
      .ny           (ny),
      .dx           (dx),
      .dy           (dy),
      .dwell        (dwell),
      .x_start      (x_start),
      .y_start      (y_start),
      .M_AXIS_XS    (xs_if),
      .M_AXIS_YS    (ys_if),
      .pixel_strobe (pixel_strobe),
      .line_dir     (line_dir),
      .pixel_idx    (pixel_idx),
      .line_idx     (line_idx),
      .busy         (busy),
      .done         (done)
   );

   typedef struct {
      longint xs, ys;
      int     pix, line;
      bit     dir, strobe, bsy, dn;
   } exp_t;

   typedef struct {
      int     nx, ny, dw;
      longint dx, dy, x0, y0;
      int     e_strobes, e_busy;
      longint e_xs, e_ys;
   } vec_t;

   exp_t   trace[$];
   vec_t   tbl[$];
   int     n_vec = 0;
   int     n_err = 0;

   function automatic longint sat(input longint v);
      if (v > 64'sd2147483647)  return 64'sd2147483647;
      if (v < -64'sd2147483647) return -64'sd2147483647;
      return v;
   endfunction

   function automatic exp_t mk(input longint xs, input longint ys, input int pix, input int line,
                               input bit dir, input bit stb, input bit bsy, input bit dn);
      exp_t e;
      e.xs = xs; e.ys = ys; e.pix = pix; e.line = line;
      e.dir = dir; e.strobe = stb; e.bsy = bsy; e.dn = dn;
      return e;
   endfunction

   // Expected cycle-by-cycle outputs of one whole scan, starting with the first FWD cycle
   // and ending with one IDLE cycle after DONE.
   task automatic build_trace(input int nxv, input int nyv, input int dwv,
                              input longint dxv, input longint dyv, input longint x0, input longint y0);
      int     d_len;
      longint xs, ys;
      d_len = (dwv == 0) ? 1 : dwv;
      xs = x0;
      ys = y0;
      trace.delete();
      for (int l = 0; l < nyv; l++) begin
         if (l > 0) begin
            trace.push_back(mk(xs, ys, nxv - 1, l - 1, 1'b1, 1'b0, 1'b1, 1'b0));
            ys = sat(ys + dyv);
         end
         for (int p = 0; p < nxv; p++) begin
            for (int d = 0; d < d_len; d++)
               trace.push_back(mk(xs, ys, p, l, 1'b0, d == d_len - 1, 1'b1, 1'b0));
            if (p < nxv - 1) xs = sat(xs + dxv);
         end
         for (int p = 0; p < nxv; p++) begin
            for (int d = 0; d < d_len; d++)
               trace.push_back(mk(xs, ys, p, l, 1'b1, d == d_len - 1, 1'b1, 1'b0));
            if (p < nxv - 1) xs = sat(xs - dxv);
         end
      end
      trace.push_back(mk(xs, ys, nxv - 1, nyv - 1, 1'b1, 1'b0, 1'b1, 1'b1));
      trace.push_back(mk(xs, ys, nxv - 1, nyv - 1, 1'b1, 1'b0, 1'b0, 1'b0));
   endtask

   task automatic tick();
      @(posedge a_clk);
      @(negedge a_clk);
   endtask

   task automatic check_val(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_cycle(input string name, input int i, input exp_t e);
      longint axs, ays;
      axs = longint'($signed(xs_if.tdata));
      ays = longint'($signed(ys_if.tdata));
      n_vec++;
      if (axs != e.xs || ays != e.ys || int'(pixel_idx) != e.pix || int'(line_idx) != e.line ||
          line_dir != e.dir || pixel_strobe != e.strobe || busy != e.bsy || done != e.dn ||
          xs_if.tvalid !== 1'b1 || ys_if.tvalid !== 1'b1) begin
         n_err++;
         $display("FAIL %s cyc %0d: got xs=%0d ys=%0d pix=%0d line=%0d dir=%0b stb=%0b busy=%0b done=%0b tv=%0b%0b, expected xs=%0d ys=%0d pix=%0d line=%0d dir=%0b stb=%0b busy=%0b done=%0b tv=11",
                  name, i, axs, ays, pixel_idx, line_idx, line_dir, pixel_strobe, busy, done,
                  xs_if.tvalid, ys_if.tvalid, e.xs, e.ys, e.pix, e.line, e.dir, e.strobe, e.bsy, e.dn);
      end
   endtask

   task automatic set_cfg(input int nxv, input int nyv, input int dwv,
                          input longint dxv, input longint dyv, input longint x0, input longint y0);
      nx = 16'(nxv); ny = 16'(nyv); dwell = 32'(dwv);
      dx = 32'(dxv); dy = 32'(dyv); x_start = 32'(x0); y_start = 32'(y0);
   endtask

   // Starts a scan, scrambles all inputs after the start cycle and fires stray start pulses
   // while busy; the trace must be unaffected by either.
   task automatic run_scan(input string name, input vec_t v,
                           output int strobes, output int busy_cyc, output int dones);
      strobes = 0; busy_cyc = 0; dones = 0;
      build_trace(v.nx, v.ny, v.dw, v.dx, v.dy, v.x0, v.y0);
      set_cfg(v.nx, v.ny, v.dw, v.dx, v.dy, v.x0, v.y0);
      start = 1'b1;
      tick();
      start = 1'b0;
      nx = 16'($urandom); ny = 16'($urandom); dwell = 32'($urandom_range(0, 5));
      dx = $urandom; dy = $urandom; x_start = $urandom; y_start = $urandom;
      for (int i = 0; i < trace.size(); i++) begin
         check_cycle(name, i, trace[i]);
         strobes  += int'(pixel_strobe);
         busy_cyc += int'(busy);
         dones    += int'(done);
         if (i < trace.size() - 1) begin
            start = ($urandom_range(0, 7) == 0);
            tick();
         end
      end
      start = 1'b0;
   endtask

   task automatic wait_busy_clear(input string name);
      int k;
      k = 0;
      while (busy && k < 200) begin
         tick();
         k++;
      end
      check_val({name, "_idle_reached"}, longint'(busy), 0);
   endtask

   initial begin
      int     s, b, d;
      int     found;
      longint xs_hold;
      vec_t   v;

      tbl.push_back('{3, 2, 2, 10, 100, -5, 0, 12, 26, -5, 100});
      tbl.push_back('{2, 1, 0, 10, 7, 0, 0, 4, 5, 0, 0});
      tbl.push_back('{3, 1, 1, 8, 0, 2147483638, 0, 6, 7, 2147483631, 0});
      tbl.push_back('{3, 1, 1, -8, 0, -2147483640, 5, 6, 7, -2147483631, 5});
      tbl.push_back('{1, 3, 3, 5, -20, 4, -7, 6, 21, 4, -47});
      tbl.push_back('{1, 3, 1, 0, 2000000000, 0, 0, 6, 9, 0, 2147483647});

      a_resetn = 1'b0; start = 1'b0; abort = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      check_val("rst_xs", longint'($signed(xs_if.tdata)), 0);
      check_val("rst_ys", longint'($signed(ys_if.tdata)), 0);
      check_val("rst_flags", longint'({pixel_strobe, line_dir, busy, done}), 0);
      check_val("rst_idx", longint'({pixel_idx, line_idx}), 0);
      check_val("rst_tvalid", longint'({xs_if.tvalid, ys_if.tvalid}), 3);

      // start accepted on the very first cycle out of reset
      set_cfg(2, 1, 1, 3, 0, 11, 22);
      a_resetn = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("first_start_busy", longint'(busy), 1);
      check_val("first_start_xs", longint'($signed(xs_if.tdata)), 11);
      wait_busy_clear("first_start");

      for (int i = 0; i < tbl.size(); i++) begin
         run_scan($sformatf("tbl%0d", i), tbl[i], s, b, d);
         check_val($sformatf("tbl%0d_strobes", i), s, tbl[i].e_strobes);
         check_val($sformatf("tbl%0d_busy", i), b, tbl[i].e_busy);
         check_val($sformatf("tbl%0d_dones", i), d, 1);
         check_val($sformatf("tbl%0d_xs", i), longint'($signed(xs_if.tdata)), tbl[i].e_xs);
         check_val($sformatf("tbl%0d_ys", i), longint'($signed(ys_if.tdata)), tbl[i].e_ys);
      end

      for (int r = 0; r < 8; r++) begin
         v.nx = $urandom_range(1, 4);
         v.ny = $urandom_range(1, 3);
         v.dw = $urandom_range(0, 3);
         v.dx = longint'($signed(32'($urandom))) >>> $urandom_range(0, 24);
         v.dy = longint'($signed(32'($urandom))) >>> $urandom_range(0, 24);
         v.x0 = ($urandom_range(0, 2) == 0) ? 64'sd2147483600 : longint'($signed(32'($urandom_range(0, 2000)))) - 1000;
         v.y0 = ($urandom_range(0, 2) == 0) ? -64'sd2147483600 : longint'($signed(32'($urandom_range(0, 2000)))) - 1000;
         run_scan($sformatf("rnd%0d", r), v, s, b, d);
         check_val($sformatf("rnd%0d_dones", r), d, 1);
      end

      // start and abort together in IDLE: abort wins
      set_cfg(3, 2, 2, 10, 100, -5, 0);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check_val("start_abort_idle_busy", longint'(busy), 0);

      // zero-sized scans are ignored
      set_cfg(0, 2, 2, 10, 100, -5, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("nx0_ignored", longint'(busy), 0);

      // abort during line 1, forward pixel 1
      set_cfg(3, 2, 2, 10, 100, -5, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      found = 0;
      for (int k = 0; k < 100; k++) begin
         if (busy && line_idx == 16'd1 && pixel_idx == 16'd1 && !line_dir) begin
            found = 1;
            break;
         end
         tick();
      end
      check_val("abort_reach", found, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("abort_busy", longint'(busy), 0);
      check_val("abort_done", longint'(done), 0);
      check_val("abort_strobe", longint'(pixel_strobe), 0);
      check_val("abort_xs", longint'($signed(xs_if.tdata)), 5);
      check_val("abort_ys", longint'($signed(ys_if.tdata)), 100);
      check_val("abort_idx", longint'({pixel_idx, line_idx}), longint'({16'd1, 16'd1}));
      d = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         d += int'(done) + int'(busy);
      end
      check_val("abort_quiet", d, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("restart_xs", longint'($signed(xs_if.tdata)), -5);
      check_val("restart_ys", longint'($signed(ys_if.tdata)), 0);
      check_val("restart_idx", longint'({pixel_idx, line_idx, line_dir}), 0);
      check_val("restart_busy", longint'(busy), 1);

      // abort coinciding with a terminal count: strobe still seen, xs does not advance
      found = 0;
      for (int k = 0; k < 20; k++) begin
         if (pixel_strobe && busy) begin
            found = 1;
            break;
         end
         tick();
      end
      check_val("abort_tc_reach", found, 1);
      xs_hold = longint'($signed(xs_if.tdata));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("abort_tc_busy", longint'(busy), 0);
      check_val("abort_tc_strobe", longint'(pixel_strobe), 0);
      check_val("abort_tc_xs", longint'($signed(xs_if.tdata)), xs_hold);

      // reset in the middle of a backward pass
      set_cfg(3, 2, 2, 10, 100, -5, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      found = 0;
      for (int k = 0; k < 100; k++) begin
         if (busy && line_dir && pixel_idx == 16'd1) begin
            found = 1;
            break;
         end
         tick();
      end
      check_val("bwd_reach", found, 1);
      a_resetn = 1'b0;
      tick();
      check_val("midrst_xs", longint'($signed(xs_if.tdata)), 0);
      check_val("midrst_ys", longint'($signed(ys_if.tdata)), 0);
      check_val("midrst_flags", longint'({pixel_strobe, line_dir, busy, done}), 0);
      check_val("midrst_idx", longint'({pixel_idx, line_idx}), 0);
      check_val("midrst_tvalid", longint'({xs_if.tvalid, ys_if.tvalid}), 3);
      a_resetn = 1'b1;
      set_cfg(3, 0, 2, 10, 100, -5, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("ny0_ignored", longint'(busy), 0);
      tick();
      check_val("ny0_still_idle", longint'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
